packet_switch_ipbb_gnt_xfer: RTL
================================

# packet_switch_ipbb_gnt_xfer

Grant consumer for the packet-switch ingress arbiter. Takes the port grant (`gnt`/`gnt_vld`), answers with the `gnt_in_flight`/`gnt_pop` handshake, and moves exactly one packet from the granted ingress stream onto a single registered egress stream. The port index is carried as `out_tid`. It sits between the per-port ingress packet buffers and the switch egress path.

## Interface
- `N`, 2: number of ingress ports (2..8).
- `N_WIDTH`, `N<2 ? 1 : $clog2(N)`: grant/port index width.
- `DATA_WD`, 64: stream data width, in bits.
- `KEEP_WD`, `DATA_WD/8`: byte-keep width.
- `CNT_WD`, 16: per-port packet counter width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gnt` in `N_WIDTH`: selected port from the arbiter.
- `gnt_vld` in 1: `gnt` is valid.
- `gnt_in_flight` out 1: a packet transfer is owned by this block. Registered.
- `gnt_pop` out 1: one-cycle pulse that retires the current grant. Registered.
- `in_tvalid` in `N`: per-port ingress valid.
- `in_tdata` in `[N][DATA_WD]`: per-port ingress data.
- `in_tkeep` in `[N][KEEP_WD]`: per-port ingress byte keep.
- `in_tlast` in `N`: per-port end-of-packet.
- `in_tready` out `N`: per-port ready. One-hot or zero.
- `out_tvalid`, `out_tdata`, `out_tkeep`, `out_tlast`, `out_tid[N_WIDTH]` out: registered egress stream.
- `out_tready` in 1: egress ready.
- `pkt_cnt` out `[N][CNT_WD]`: packets forwarded per port. Wraps.

## Operation
- FSM states: IDLE, XFER, POP.
- IDLE:
  - `gnt_in_flight`=0, `gnt_pop`=0, all `in_tready`=0.
  - If `gnt_vld`=1, latch `sel`←`gnt` and go to XFER.
- XFER:
  - `gnt_in_flight`=1.
  - `in_tready[sel]` = `!out_tvalid | out_tready`. All other `in_tready` bits are 0.
  - A beat is accepted when `in_tvalid[sel] & in_tready[sel]`.
  - On an accepted beat, load `out_tdata`/`out_tkeep`/`out_tlast` from port `sel`, load `out_tid`←`sel`, and set `out_tvalid`=1.
  - An accepted beat with `in_tlast`=1 increments `pkt_cnt[sel]` (mod 2^CNT_WD) and moves the FSM to POP.
  - `gnt`/`gnt_vld` changes during XFER are ignored; `sel` is held.
- POP (exactly 1 cycle):
  - `gnt_pop`=1, `gnt_in_flight`=1, `in_tready`=0.
  - Next state is IDLE unconditionally.
  - `gnt_in_flight` stays high here so the arbiter still presents `gnt==sel` while the pop is seen.
- IDLE is never skipped. The arbiter only accepts a new grant in a cycle where `gnt_in_flight`=0 and `gnt_pop`=0.
- Egress register:
  - `out_tvalid` clears when `out_tready`=1 and no new beat is loaded in the same cycle.
  - Simultaneous drain and load keeps `out_tvalid`=1 with the new data.
  - Egress data is held stable while `out_tvalid & !out_tready`.
  - The egress register keeps draining during POP and IDLE, independent of the FSM.
- Zero-length packets do not exist. A 1-beat packet has `tlast` on its first beat.
- `gnt` outside `0..N-1` while `gnt_vld`=1 is illegal. No response is defined; the bench asserts that it never occurs.
- Reset (`rst_n`=0, any time, including mid-packet):
  - FSM→IDLE, `sel`=0.
  - `gnt_in_flight`=0, `gnt_pop`=0, `in_tready`=0.
  - `out_tvalid`=0, `out_tdata`/`out_tkeep`/`out_tlast`/`out_tid`=0.
  - `pkt_cnt`=0.
  - A partially transferred packet is dropped. The ingress buffers and the arbiter are reset by the same reset domain.

## Timing
- `gnt_vld` sampled in IDLE at cycle t → XFER at t+1, with `gnt_in_flight`=1 and `in_tready[sel]` possible at t+1.
- Beat accepted at cycle c → `out_tvalid` with that beat at c+1.
- Throughput within a packet: 1 beat/cycle while `out_tready`=1.
- Last beat accepted at cycle L → POP at L+1 (`gnt_pop`=1) → IDLE at L+2 (`gnt_in_flight`=0) → earliest next XFER at L+3.
- Minimum packet-to-packet period is beats+2 cycles.
- Every state-decoded output is a flop output. There is no combinational path from `gnt`/`gnt_vld` to any output.
- `in_tready[sel]` depends combinationally on `out_tready` and `out_tvalid` only.

## Test plan
- Single 1-beat packet on port 1:
  - Stimulus: `gnt`=1, `gnt_vld` at t; `out_tready`=1.
  - Required: `in_tready[1]`=1 at t+1; `out_tvalid`/`out_tlast`=1 and `out_tid`=1 at t+2; `gnt_pop`=1 at t+2 only; `gnt_in_flight` high t+1..t+2; `pkt_cnt[1]`=1.
- 8-beat packet on port 0 with `out_tready` toggled 1,0,1,0:
  - Required: all 8 beats appear in order with no loss or duplication; `out_tdata` is stable while stalled; `gnt_pop` fires exactly once, one cycle after the last beat is accepted.
- Back-to-back grants with `gnt_vld` held high, alternating ports 0/1, 2-beat packets:
  - Required: each packet takes 4 cycles; there is exactly one IDLE cycle with `gnt_in_flight`=0 between packets; `gnt_pop` is never coincident with IDLE.
- `gnt` changed from 2 to 0 mid-XFER (N=4):
  - Required: the transfer continues on port 2 to `tlast`; `in_tready[0]` stays 0.
- `rst_n` asserted on beat 3 of a 6-beat packet:
  - Required: all outputs are 0 immediately and asynchronously; after release the FSM is in IDLE and `pkt_cnt` is all 0.
- `pkt_cnt` wrap with `CNT_WD`=4:
  - Stimulus: 17 packets on port 3.
  - Required: `pkt_cnt[3]`=1; all other counters are 0.

Source files
------------

// File: rtl/packet_switch_ipbb_gnt_xfer.sv
// Grant consumer for the ingress arbiter: takes one port grant, forwards exactly
// one packet from that port onto a registered egress stream, then pops the grant.
module packet_switch_ipbb_gnt_xfer #(
  parameter int N       = 2,
  parameter int N_WIDTH = (N < 2) ? 1 : $clog2(N),
  parameter int DATA_WD = 64,
  parameter int KEEP_WD = DATA_WD / 8,
  parameter int CNT_WD  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_WIDTH-1:0]            gnt,
  input  logic                          gnt_vld,
  output logic                          gnt_in_flight,
  output logic                          gnt_pop,
  input  logic [N-1:0]                  in_tvalid,
  input  logic [N-1:0][DATA_WD-1:0]     in_tdata,
  input  logic [N-1:0][KEEP_WD-1:0]     in_tkeep,
  input  logic [N-1:0]                  in_tlast,
  output logic [N-1:0]                  in_tready,
  output logic                          out_tvalid,
  output logic [DATA_WD-1:0]            out_tdata,
  output logic [KEEP_WD-1:0]            out_tkeep,
  output logic                          out_tlast,
  output logic [N_WIDTH-1:0]            out_tid,
  input  logic                          out_tready,
  output logic [N-1:0][CNT_WD-1:0]      pkt_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, POP} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] sel;
  logic               xfer;
  logic               room;
  logic [N-1:0]       take;
  logic               accept;
  logic               last;
  logic [DATA_WD-1:0] mux_data;
  logic [KEEP_WD-1:0] mux_keep;

  assign xfer   = (state == XFER);
  // Egress slot is free if empty or draining this cycle.
  assign room   = !out_tvalid | out_tready;
  assign accept = |take;
  assign last   = |(take & in_tlast);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CNT_WD-1:0] cnt;

    assign in_tready[i] = xfer & room & (sel == N_WIDTH'(i));
    assign take[i]      = in_tready[i] & in_tvalid[i];
    assign pkt_cnt[i]   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (take[i] && in_tlast[i]) cnt <= cnt + CNT_WD'(1);
    end
  end

  // take is one-hot or zero, so an OR-reduce is the port mux.
  always_comb begin
    mux_data = '0;
    mux_keep = '0;
    for (int i = 0; i < N; i++) begin
      if (take[i]) begin
        mux_data = mux_data | in_tdata[i];
        mux_keep = mux_keep | in_tkeep[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tdata  <= mux_data;
      out_tkeep  <= mux_keep;
      out_tlast  <= last;
      out_tid    <= sel;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  // gnt_in_flight stays up through POP so the arbiter keeps gnt==sel while the pop is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= '0;
      gnt_in_flight <= 1'b0;
      gnt_pop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt_pop <= 1'b0;
          if (gnt_vld) begin
            sel           <= gnt;
            state         <= XFER;
            gnt_in_flight <= 1'b1;
          end
        end
        XFER: begin
          if (accept && last) begin
            state   <= POP;
            gnt_pop <= 1'b1;
          end
        end
        POP: begin
          state         <= IDLE;
          gnt_pop       <= 1'b0;
          gnt_in_flight <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          gnt_pop       <= 1'b0;
          gnt_in_flight <= 1'b0;
        end
      endcase
    end
  end

endmodule
